// File: rtl/kizilelma_ccu.sv
`default_nettype none
// ============================================================================
// Module   : kizilelma_ccu
// Purpose  : Combat control unit. A target tracking unit (TTU) pulses the
//            radar transmitter, times the echo and reports range. A weapons
//            control unit (WCU) locks on while the TTU tracks and launches
//            missiles from a finite magazine on operator command.
// Ports    : clk, rst                    - clock, async active-high reset
//            track_target_command        - level-sampled ranging request
//            radar_echo                  - echo pulse, may be sub-cycle
//            fire_command                - operator fire request
//            distance_to_target[13:0]    - last measured range (m)
//            trigger_radar_transmitter   - radar transmit enable
//            launch_missile              - one-cycle launch strobe
//            TTU_state[1:0], WCU_state[1:0], remaining_missiles[3:0]
// Config   : CCU_FIRE_EDGE_EN defined   -> fire on rising edge of fire_command
//            CCU_FIRE_EDGE_EN undefined -> fire on fire_command level in LOCKED
// Revision : 1.0 - initial release
// ============================================================================
module kizilelma_ccu #(
    parameter int CLK_PERIOD_US = 10,
    parameter int TX_CYCLES     = 5,
    parameter int LISTEN_CYCLES = 10,
    parameter int TRACK_CYCLES  = 30,
    parameter int M_PER_CYCLE   = 1500,
    parameter int MISSILES      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        track_target_command,
    input  logic        radar_echo,
    input  logic        fire_command,
    output logic [13:0] distance_to_target,
    output logic        trigger_radar_transmitter,
    output logic        launch_missile,
    output logic [1:0]  TTU_state,
    output logic [1:0]  WCU_state,
    output logic [3:0]  remaining_missiles
);

    // Range per listen cycle must follow the 150 m/us round-trip figure.
    if (MISSILES < 1 || MISSILES > 15 || M_PER_CYCLE != 150 * CLK_PERIOD_US) begin : g_bad_params
        $error("kizilelma_ccu: inconsistent parameters");
    end

    localparam int c_CNT_MAX_A = (TX_CYCLES > LISTEN_CYCLES) ? TX_CYCLES : LISTEN_CYCLES;
    localparam int c_CNT_MAX   = (c_CNT_MAX_A > TRACK_CYCLES) ? c_CNT_MAX_A : TRACK_CYCLES;
    localparam int c_CNT_W     = $clog2(c_CNT_MAX + 1);
    localparam int c_MAX_RANGE = 15000;

    localparam logic [c_CNT_W-1:0] c_ONE        = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_TX_END     = c_CNT_W'(TX_CYCLES);
    localparam logic [c_CNT_W-1:0] c_LISTEN_END = c_CNT_W'(LISTEN_CYCLES);
    localparam logic [c_CNT_W-1:0] c_TRACK_END  = c_CNT_W'(TRACK_CYCLES);

    typedef enum logic [1:0] {
        TTU_IDLE     = 2'b00,
        TTU_TRANSMIT = 2'b01,
        TTU_LISTEN   = 2'b10,
        TTU_TRACK    = 2'b11
    } ttu_state_t;

    typedef enum logic [1:0] {
        WCU_IDLE        = 2'b00,
        WCU_LOCKED      = 2'b01,
        WCU_FIRE        = 2'b10,
        WCU_OUT_OF_AMMO = 2'b11
    } wcu_state_t;

    ttu_state_t         r_ttu;
    wcu_state_t         r_wcu;
    logic [c_CNT_W-1:0] r_cnt;          // 1-based cycle count inside the current TTU state
    logic [13:0]        r_distance;
    logic               r_trigger;
    logic               r_launch;
    logic [3:0]         r_remaining;
    logic               r_echo_tgl;     // toggles on every echo rising edge
    logic               r_echo_ack;     // clk-domain copy taken on LISTEN entry
    logic               w_echo_flag;
    logic               w_fire_event;
    logic [13:0]        w_range;

    // ------------------------------------------------------------------------
    // Echo capture. A pulse narrower than a clock period is caught by the
    // toggle flop; the flag reads "set" while toggle and acknowledge differ.
    // Taking a fresh acknowledge on LISTEN entry clears it synchronously, so
    // echoes seen during TRANSMIT are discarded.
    // ------------------------------------------------------------------------
    always_ff @(posedge radar_echo or posedge rst) begin
        if (rst) begin
            r_echo_tgl <= 1'b0;
        end else begin
            r_echo_tgl <= ~r_echo_tgl;
        end
    end

    assign w_echo_flag = (r_echo_tgl ^ r_echo_ack) | radar_echo;

    // Range for an echo ending listen cycle r_cnt, saturated at 15 km.
    always_comb begin
        if (int'(r_cnt) * M_PER_CYCLE > c_MAX_RANGE) begin
            w_range = 14'(c_MAX_RANGE);
        end else begin
            w_range = 14'(int'(r_cnt) * M_PER_CYCLE);
        end
    end

`ifdef CCU_FIRE_EDGE_EN
    logic r_fire_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fire_d <= 1'b0;
        end else begin
            r_fire_d <= fire_command;
        end
    end

    assign w_fire_event = fire_command & ~r_fire_d;
`else
    assign w_fire_event = fire_command;
`endif

    // ------------------------------------------------------------------------
    // Target tracking unit
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ttu      <= TTU_IDLE;
            r_cnt      <= '0;
            r_distance <= '0;
            r_trigger  <= 1'b0;
            r_echo_ack <= 1'b0;
        end else begin
            case (r_ttu)
                TTU_IDLE: begin
                    if (track_target_command) begin
                        r_ttu     <= TTU_TRANSMIT;
                        r_cnt     <= c_ONE;
                        r_trigger <= 1'b1;
                    end
                end
                TTU_TRANSMIT: begin
                    if (r_cnt == c_TX_END) begin
                        r_ttu      <= TTU_LISTEN;
                        r_cnt      <= c_ONE;
                        r_trigger  <= 1'b0;
                        r_echo_ack <= r_echo_tgl;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                TTU_LISTEN: begin
                    // An echo in the last listen cycle still counts as a hit.
                    if (w_echo_flag) begin
                        r_ttu      <= TTU_TRACK;
                        r_cnt      <= c_ONE;
                        r_distance <= w_range;
                    end else if (r_cnt == c_LISTEN_END) begin
                        r_ttu      <= TTU_IDLE;
                        r_distance <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                TTU_TRACK: begin
                    if (track_target_command) begin
                        r_ttu     <= TTU_TRANSMIT;
                        r_cnt     <= c_ONE;
                        r_trigger <= 1'b1;
                    end else if (r_cnt == c_TRACK_END) begin
                        r_ttu <= TTU_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                default: begin
                    r_ttu <= TTU_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Weapons control unit. Follows the registered TTU state, so lock and
    // unlock both lag the TTU by one cycle; loss of track beats a fire event.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcu       <= WCU_IDLE;
            r_launch    <= 1'b0;
            r_remaining <= 4'(MISSILES);
        end else begin
            case (r_wcu)
                WCU_IDLE: begin
                    r_launch <= 1'b0;
                    if (r_ttu == TTU_TRACK) begin
                        r_wcu <= WCU_LOCKED;
                    end
                end
                WCU_LOCKED: begin
                    if (r_ttu != TTU_TRACK) begin
                        r_wcu <= WCU_IDLE;
                    end else if (w_fire_event && (r_remaining != 4'd0)) begin
                        r_wcu       <= WCU_FIRE;
                        r_launch    <= 1'b1;
                        r_remaining <= r_remaining - 4'd1;
                    end
                end
                WCU_FIRE: begin
                    r_launch <= 1'b0;
                    if (r_remaining == 4'd0) begin
                        r_wcu <= WCU_OUT_OF_AMMO;
                    end else if (r_ttu == TTU_TRACK) begin
                        r_wcu <= WCU_LOCKED;
                    end else begin
                        r_wcu <= WCU_IDLE;
                    end
                end
                default: begin
                    r_launch <= 1'b0;
                end
            endcase
        end
    end

    assign distance_to_target        = r_distance;
    assign trigger_radar_transmitter = r_trigger;
    assign launch_missile            = r_launch;
    assign TTU_state                 = r_ttu;
    assign WCU_state                 = r_wcu;
    assign remaining_missiles        = r_remaining;

endmodule
`default_nettype wire

// File: tb/tb_kizilelma_ccu.sv
`default_nettype none
// ============================================================================
// Module   : tb_kizilelma_ccu
// Purpose  : Self-checking bench for kizilelma_ccu: directed scenarios with
//            fixed expectations plus a randomized run against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kizilelma_ccu;

    localparam int TX   = 5;
    localparam int LSN  = 10;
    localparam int TRK  = 30;
    localparam int MPC  = 1500;
    localparam int NMIS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        track_target_command = 1'b0;
    logic        radar_echo = 1'b0;
    logic        fire_command = 1'b0;
    logic [13:0] distance_to_target;
    logic        trigger_radar_transmitter;
    logic        launch_missile;
    logic [1:0]  TTU_state;
    logic [1:0]  WCU_state;
    logic [3:0]  remaining_missiles;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    kizilelma_ccu #(
        .CLK_PERIOD_US (10),
        .TX_CYCLES     (TX),
        .LISTEN_CYCLES (LSN),
        .TRACK_CYCLES  (TRK),
        .M_PER_CYCLE   (MPC),
        .MISSILES      (NMIS)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .track_target_command      (track_target_command),
        .radar_echo                (radar_echo),
        .fire_command              (fire_command),
        .distance_to_target        (distance_to_target),
        .trigger_radar_transmitter (trigger_radar_transmitter),
        .launch_missile            (launch_missile),
        .TTU_state                 (TTU_state),
        .WCU_state                 (WCU_state),
        .remaining_missiles        (remaining_missiles)
    );

    wire [23:0] dut_vec = {TTU_state, WCU_state, distance_to_target,
                           trigger_radar_transmitter, launch_missile, remaining_missiles};

    // ---------------- reference model (phase + elapsed-cycle view) ----------
    int m_ttu, m_wcu, m_t, m_dist, m_rem;
    bit m_trig, m_launch, m_echo, m_fire_prev;

    function automatic void model_reset();
        m_ttu = 0; m_wcu = 0; m_t = 0; m_dist = 0; m_rem = NMIS;
        m_trig = 0; m_launch = 0; m_echo = 0; m_fire_prev = 0;
    endfunction

    function automatic void model_step(input bit c, input bit f);
        int old_ttu;
        bit ev;
        old_ttu = m_ttu;
`ifdef CCU_FIRE_EDGE_EN
        ev = f && !m_fire_prev;
`else
        ev = f;
`endif
        m_fire_prev = f;
        m_t = m_t + 1;  // cycles completed in the current radar phase
        case (old_ttu)
            0: if (c) begin m_ttu = 1; m_t = 0; end
            1: if (m_t == TX) begin m_ttu = 2; m_t = 0; m_echo = 0; end
            2: begin
                if (m_echo) begin
                    m_ttu = 3;
                    m_dist = (m_t * MPC > 15000) ? 15000 : m_t * MPC;
                    m_t = 0;
                end else if (m_t == LSN) begin
                    m_ttu = 0; m_dist = 0; m_t = 0;
                end
            end
            default: begin
                if (c) begin m_ttu = 1; m_t = 0; end
                else if (m_t == TRK) begin m_ttu = 0; m_t = 0; end
            end
        endcase
        m_trig = (m_ttu == 1);
        case (m_wcu)
            0: if (old_ttu == 3) m_wcu = 1;
            1: begin
                if (old_ttu != 3) m_wcu = 0;
                else if (ev && m_rem > 0) begin m_wcu = 2; m_rem = m_rem - 1; end
            end
            2: m_wcu = (m_rem == 0) ? 3 : ((old_ttu == 3) ? 1 : 0);
            default: m_wcu = 3;
        endcase
        m_launch = (m_wcu == 2);
    endfunction

    function automatic logic [23:0] model_vec();
        logic [1:0]  t2, w2;
        logic [13:0] d14;
        logic [3:0]  r4;
        t2 = m_ttu[1:0]; w2 = m_wcu[1:0]; d14 = m_dist[13:0]; r4 = m_rem[3:0];
        return {t2, w2, d14, m_trig, m_launch, r4};
    endfunction

    // ---------------- stimulus primitives ----------------------------------
    // One clock cycle: inputs set at negedge, optional sub-cycle echo pulse,
    // model advanced at the posedge, outputs settle 1 unit later.
    task automatic cyc(input bit c, input bit f, input bit e);
        @(negedge clk);
        track_target_command = c;
        fire_command = f;
        if (e) begin
            #1 radar_echo = 1'b1;
            #2 radar_echo = 1'b0;
            m_echo = 1;
        end
        @(posedge clk);
        model_step(c, f);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        track_target_command = 1'b0;
        fire_command = 1'b0;
        radar_echo = 1'b0;
        @(posedge clk);
        model_step(0, 0);
        #1;
    endtask

    // Issue a track command and run until the first LISTEN cycle begins.
    task automatic start_listen();
        cyc(1, 0, 0);
        repeat (TX) cyc(0, 0, 0);
    endtask

    // ---------------- scenarios --------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++; if (TTU_state !== 2'b00) begin failures++; $display("FAIL reset_ttu: got %b expected 00", TTU_state); end
        checks++; if (WCU_state !== 2'b00) begin failures++; $display("FAIL reset_wcu: got %b expected 00", WCU_state); end
        checks++; if (distance_to_target !== 14'd0) begin failures++; $display("FAIL reset_dist: got %0d expected 0", distance_to_target); end
        checks++; if (trigger_radar_transmitter !== 1'b0) begin failures++; $display("FAIL reset_trig: got %b expected 0", trigger_radar_transmitter); end
        checks++; if (launch_missile !== 1'b0) begin failures++; $display("FAIL reset_launch: got %b expected 0", launch_missile); end
        checks++; if (remaining_missiles !== 4'd2) begin failures++; $display("FAIL reset_rem: got %0d expected 2", remaining_missiles); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_step(0, 0);
        #1;
        checks++; if (TTU_state !== 2'b00) begin failures++; $display("FAIL reset_idle_hold: got %b expected 00", TTU_state); end
    endtask

    task automatic test_track_echo();
        int hi;
        hi = 0;
        do_reset();
        cyc(1, 0, 0);
        checks++; if (TTU_state !== 2'b01) begin failures++; $display("FAIL cmd_latency: got %b expected 01", TTU_state); end
        if (trigger_radar_transmitter === 1'b1) hi++;
        for (int i = 0; i < TX; i++) begin
            cyc(0, 0, 0);
            if (trigger_radar_transmitter === 1'b1) hi++;
        end
        checks++; if (hi != TX) begin failures++; $display("FAIL trig_width: got %0d expected %0d", hi, TX); end
        checks++; if (TTU_state !== 2'b10) begin failures++; $display("FAIL enter_listen: got %b expected 10", TTU_state); end
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        checks++; if (TTU_state !== 2'b11) begin failures++; $display("FAIL echo_track: got %b expected 11", TTU_state); end
        checks++; if (distance_to_target !== 14'd4500) begin failures++; $display("FAIL echo_dist: got %0d expected 4500", distance_to_target); end
        checks++; if (WCU_state !== 2'b00) begin failures++; $display("FAIL lock_early: got %b expected 00", WCU_state); end
        cyc(0, 0, 0);
        checks++; if (WCU_state !== 2'b01) begin failures++; $display("FAIL lock_latency: got %b expected 01", WCU_state); end
    endtask

    // Continues from TRACK at 4500 m: re-range with no echo.
    task automatic test_no_echo();
        start_listen();
        checks++; if (distance_to_target !== 14'd4500) begin failures++; $display("FAIL dist_held: got %0d expected 4500", distance_to_target); end
        repeat (LSN - 1) cyc(0, 0, 0);
        checks++; if (TTU_state !== 2'b10) begin failures++; $display("FAIL listen_9: got %b expected 10", TTU_state); end
        cyc(0, 0, 0);
        checks++; if (TTU_state !== 2'b00) begin failures++; $display("FAIL no_echo_idle: got %b expected 00", TTU_state); end
        checks++; if (distance_to_target !== 14'd0) begin failures++; $display("FAIL no_echo_dist: got %0d expected 0", distance_to_target); end
        checks++; if (WCU_state !== 2'b00) begin failures++; $display("FAIL no_echo_wcu: got %b expected 00", WCU_state); end
    endtask

    task automatic test_fire();
        int launches;
        int exp_l[3];
        int exp_r[3];
        int exp_w[3];
        exp_l[0] = 1; exp_l[1] = 2; exp_l[2] = 2;
        exp_r[0] = 1; exp_r[1] = 0; exp_r[2] = 0;
        exp_w[0] = 1; exp_w[1] = 3; exp_w[2] = 3;
        launches = 0;
        do_reset();
        // fire while WCU idle is discarded
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        checks++; if (remaining_missiles !== 4'd2) begin failures++; $display("FAIL idle_fire: got %0d expected 2", remaining_missiles); end
        start_listen();
        cyc(0, 0, 1);
        checks++; if (distance_to_target !== 14'd1500) begin failures++; $display("FAIL first_cycle_dist: got %0d expected 1500", distance_to_target); end
        cyc(0, 0, 0);
        for (int p = 0; p < 3; p++) begin
            cyc(0, 1, 0); if (launch_missile === 1'b1) launches++;
            cyc(0, 1, 0); if (launch_missile === 1'b1) launches++;
            cyc(0, 0, 0); if (launch_missile === 1'b1) launches++;
            cyc(0, 0, 0); if (launch_missile === 1'b1) launches++;
            checks++; if (launches != exp_l[p]) begin failures++; $display("FAIL launches_%0d: got %0d expected %0d", p, launches, exp_l[p]); end
            checks++; if (int'(remaining_missiles) != exp_r[p]) begin failures++; $display("FAIL remaining_%0d: got %0d expected %0d", p, remaining_missiles, exp_r[p]); end
            checks++; if (int'(WCU_state) != exp_w[p]) begin failures++; $display("FAIL wcu_after_%0d: got %0d expected %0d", p, WCU_state, exp_w[p]); end
        end
        checks++; if (TTU_state !== 2'b11) begin failures++; $display("FAIL ttu_after_fire: got %b expected 11", TTU_state); end
    endtask

    task automatic test_track_timeout();
        do_reset();
        start_listen();
        cyc(0, 0, 1);
        repeat (TRK - 1) cyc(0, 0, 0);
        checks++; if (TTU_state !== 2'b11) begin failures++; $display("FAIL track_29: got %b expected 11", TTU_state); end
        cyc(0, 0, 0);
        checks++; if (TTU_state !== 2'b00) begin failures++; $display("FAIL track_timeout: got %b expected 00", TTU_state); end
        checks++; if (WCU_state !== 2'b01) begin failures++; $display("FAIL unlock_early: got %b expected 01", WCU_state); end
        cyc(0, 0, 0);
        checks++; if (WCU_state !== 2'b00) begin failures++; $display("FAIL unlock_latency: got %b expected 00", WCU_state); end
        start_listen();
        cyc(0, 0, 1);
        repeat (TRK - 2) cyc(0, 0, 0);
        cyc(1, 0, 0);
        checks++; if (TTU_state !== 2'b01) begin failures++; $display("FAIL retrack_29: got %b expected 01", TTU_state); end
        checks++; if (trigger_radar_transmitter !== 1'b1) begin failures++; $display("FAIL retrack_trig: got %b expected 1", trigger_radar_transmitter); end
    endtask

    task automatic test_reset_mid_listen();
        do_reset();
        start_listen();
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        repeat (2) begin
            cyc(0, 1, 0);
            cyc(0, 0, 0);
        end
        start_listen();
        checks++; if (TTU_state !== 2'b10 || remaining_missiles !== 4'd0) begin
            failures++; $display("FAIL pre_reset: got ttu=%b rem=%0d expected ttu=10 rem=0", TTU_state, remaining_missiles);
        end
        @(negedge clk);
        #1 radar_echo = 1'b1;
        #1 radar_echo = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        #1;
        checks++; if (dut_vec !== {2'b00, 2'b00, 14'd0, 1'b0, 1'b0, 4'd2}) begin
            failures++; $display("FAIL reset_mid_listen: got %h expected %h", dut_vec, {2'b00, 2'b00, 14'd0, 1'b0, 1'b0, 4'd2});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_step(0, 0);
        #1;
        start_listen();
        cyc(0, 0, 0);
        checks++; if (TTU_state !== 2'b10) begin failures++; $display("FAIL flag_cleared: got %b expected 10", TTU_state); end
    endtask

    task automatic test_random();
        bit c, f, e;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            c = ($urandom_range(0, 9) == 0);
            f = ($urandom_range(0, 3) == 0);
            e = ($urandom_range(0, 5) == 0);
            cyc(c, f, e);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_track_echo();
        test_no_echo();
        test_fire();
        test_track_timeout();
        test_reset_mid_listen();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
